// File: rtl/stack_controller_pkg.sv
// rtl/stack_controller_pkg.sv - shared types and opcode stack profiles for the operand stack controller
package stack_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_CAP  = 3'd3,
        ST_OPND = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_ILLEGAL   = 2'd3
    } err_t;

    // {entries read, entries popped, result pushed} per decoded opcode
    typedef struct packed {
        logic [1:0] rd;
        logic [1:0] pop;
        logic       push;
    } stack_op_t;

    localparam stack_op_t OP_ADD    = '{rd: 2'd2, pop: 2'd2, push: 1'b1};
    localparam stack_op_t OP_MUL    = '{rd: 2'd2, pop: 2'd2, push: 1'b1};
    localparam stack_op_t OP_LT     = '{rd: 2'd2, pop: 2'd2, push: 1'b1};
    localparam stack_op_t OP_EQ     = '{rd: 2'd2, pop: 2'd2, push: 1'b1};
    localparam stack_op_t OP_ISZERO = '{rd: 2'd1, pop: 2'd1, push: 1'b1};
    localparam stack_op_t OP_POP    = '{rd: 2'd1, pop: 2'd1, push: 1'b0};
    localparam stack_op_t OP_JUMPI  = '{rd: 2'd2, pop: 2'd2, push: 1'b0};
    localparam stack_op_t OP_PUSH0  = '{rd: 2'd0, pop: 2'd0, push: 1'b1};
    localparam stack_op_t OP_PUSH1  = '{rd: 2'd0, pop: 2'd0, push: 1'b1};
    localparam stack_op_t OP_DUP1   = '{rd: 2'd1, pop: 2'd0, push: 1'b1};

endpackage

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - sequences operand fetch and result write-back on an external single-port stack RAM
module stack_controller
    import stack_controller_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 32,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_rd,
    input  logic [1:0]        op_pop,
    input  logic              op_push,
    output logic              opnd_valid,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [PTR_W-2:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PTR_W-1:0]  sp,
    output logic              halted,
    output logic [1:0]        err_code
);

    localparam int SPW = PTR_W + 1;

    state_t           state, state_nx;
    err_t             err_q, acc_err;
    logic [1:0]       req_rd, req_pop;
    logic             req_push;
    logic [PTR_W-1:0] sp_m1, sp_m2, wr_ptr;

    // One extra bit so sp-pop+push can exceed DEPTH without wrapping
    function automatic err_t check_op(input logic [1:0] rd, input logic [1:0] pop,
                                      input logic push, input logic [PTR_W-1:0] cur_sp);
        logic [SPW-1:0] next_sp;
        next_sp = {1'b0, cur_sp} - SPW'(pop) + SPW'(push);
        if (pop > rd)
            return ERR_ILLEGAL;
        else if (PTR_W'(rd) > cur_sp)
            return ERR_UNDERFLOW;
        else if (next_sp > SPW'(DEPTH))
            return ERR_OVERFLOW;
        return ERR_NONE;
    endfunction

    assign acc_err  = check_op(op_rd, op_pop, op_push, sp);
    assign sp_m1    = sp - PTR_W'(1);
    assign sp_m2    = sp - PTR_W'(2);
    assign wr_ptr   = sp - PTR_W'(req_pop);
    assign halted   = (state == ST_HALT);
    assign err_code = err_q;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (acc_err != ERR_NONE)
                        state_nx = ST_HALT;
                    else if (op_rd != 2'd0)
                        state_nx = ST_RD_A;
                    else
                        state_nx = ST_OPND;
                end
            end
            ST_RD_A: state_nx = (req_rd == 2'd2) ? ST_RD_B : ST_CAP;
            ST_RD_B: state_nx = ST_CAP;
            ST_CAP:  state_nx = ST_OPND;
            ST_OPND: if (res_valid) state_nx = ST_IDLE;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready   = 1'b0;
        opnd_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: op_ready = 1'b1;
            ST_RD_A: begin
                mem_en   = 1'b1;
                mem_addr = sp_m1[PTR_W-2:0];
            end
            ST_RD_B: begin
                mem_en   = 1'b1;
                mem_addr = sp_m2[PTR_W-2:0];
            end
            ST_OPND: begin
                opnd_valid = 1'b1;
                if (res_valid && req_push) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_ptr[PTR_W-2:0];
                    mem_wdata = res_data;
                end
            end
            default: ;
        endcase
        // Reset must abort a write-back that is being presented this cycle
        if (!rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp       <= '0;
            err_q    <= ERR_NONE;
            opnd_a   <= '0;
            opnd_b   <= '0;
            req_rd   <= '0;
            req_pop  <= '0;
            req_push <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        req_rd   <= op_rd;
                        req_pop  <= op_pop;
                        req_push <= op_push;
                        opnd_a   <= '0;
                        opnd_b   <= '0;
                        if (acc_err != ERR_NONE)
                            err_q <= acc_err;
                    end
                end
                ST_RD_B: opnd_a <= mem_rdata;
                ST_CAP: begin
                    if (req_rd == 2'd2)
                        opnd_b <= mem_rdata;
                    else
                        opnd_a <= mem_rdata;
                end
                ST_OPND: begin
                    if (res_valid)
                        sp <= sp - PTR_W'(req_pop) + PTR_W'(req_push);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - scoreboard bench for stack_controller with a behavioural stack RAM
module tb_stack_controller;
    import stack_controller_pkg::*;

    localparam int DATA_W = 17;
    localparam int DEPTH  = 32;
    localparam int PTR_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [1:0]        op_rd = '0;
    logic [1:0]        op_pop = '0;
    logic              op_push = 1'b0;
    logic              opnd_valid;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    logic              res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic              mem_en, mem_we;
    logic [PTR_W-2:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [PTR_W-1:0]  sp;
    logic              halted;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    stack_controller #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rd(op_rd), .op_pop(op_pop), .op_push(op_push),
        .opnd_valid(opnd_valid), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .res_valid(res_valid), .res_data(res_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sp(sp), .halted(halted), .err_code(err_code)
    );

    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        int                lat;
    } exp_t;

    exp_t sb[$];
    int   model[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        op_valid = 1'b0;
        res_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_ready", 32'(op_ready), 1);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(err_code), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_opnd_valid", 32'(opnd_valid), 0);
        chk("rst_opnd_a", 32'(opnd_a), 0);
        rst = 1'b1;
        model.delete();
        sb.delete();
    endtask

    task automatic issue(input int rd, input int pop, input int push, output int err_exp);
        int   n;
        int   sp_m;
        exp_t e;
        sp_m = model.size();
        if (pop > rd)                   err_exp = 3;
        else if (rd > sp_m)             err_exp = 1;
        else if (sp_m - pop + push > DEPTH) err_exp = 2;
        else                            err_exp = 0;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_wait", 32'(op_ready), 1);
        op_valid = 1'b1;
        op_rd    = rd[1:0];
        op_pop   = pop[1:0];
        op_push  = push[0];
        if (err_exp == 0) begin
            e.a   = (rd >= 1) ? DATA_W'(model[sp_m-1]) : '0;
            e.b   = (rd == 2) ? DATA_W'(model[sp_m-2]) : '0;
            e.lat = (rd == 0) ? 1 : ((rd == 1) ? 3 : 4);
            sb.push_back(e);
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic check_halt(input int code);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_err", 32'(err_code), code);
        chk("halt_ready", 32'(op_ready), 0);
        chk("halt_opnd_valid", 32'(opnd_valid), 0);
        chk("halt_mem_en", 32'(mem_en), 0);
        op_valid = 1'b1;
        op_rd = 2'd0; op_pop = 2'd0; op_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_stuck_ready", 32'(op_ready), 0);
            chk("halt_stuck_mem_en", 32'(mem_en), 0);
            chk("halt_stuck_flag", 32'(halted), 1);
        end
        op_valid = 1'b0;
    endtask

    task automatic run_op(input int rd, input int pop, input int push, input logic [DATA_W-1:0] res);
        int               err_exp, lat, nrd, sp_m;
        exp_t             e;
        logic [PTR_W-2:0] rd_addr [2];
        sp_m = model.size();
        issue(rd, pop, push, err_exp);
        if (err_exp != 0) begin
            check_halt(err_exp);
            return;
        end
        lat = 1;
        nrd = 0;
        while (!opnd_valid && lat < 10) begin
            if (mem_en) begin
                if (nrd < 2) rd_addr[nrd] = mem_addr;
                nrd++;
                chk("rd_no_we", 32'(mem_we), 0);
            end
            @(negedge clk);
            lat++;
        end
        chk("opnd_valid_seen", 32'(opnd_valid), 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("opnd_a", 32'(opnd_a), 32'(e.a));
        chk("opnd_b", 32'(opnd_b), 32'(e.b));
        chk("rd_count", 32'(nrd), 32'(rd));
        for (int i = 0; i < rd && i < 2; i++)
            chk("rd_addr", 32'(rd_addr[i]), 32'(sp_m - 1 - i));
        @(negedge clk);
        chk("hold_valid", 32'(opnd_valid), 1);
        chk("hold_a", 32'(opnd_a), 32'(e.a));
        chk("hold_b", 32'(opnd_b), 32'(e.b));
        res_valid = 1'b1;
        res_data  = res;
        #1;
        chk("wr_we", 32'(mem_we), 32'(push));
        if (push != 0) begin
            chk("wr_addr", 32'(mem_addr), 32'(sp_m - pop));
            chk("wr_data", 32'(mem_wdata), 32'(res));
        end
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 0; i < pop; i++) void'(model.pop_back());
        if (push != 0) model.push_back(int'(res));
        chk("sp_after", 32'(sp), 32'(model.size()));
        chk("ready_after", 32'(op_ready), 1);
    endtask

    task automatic run_code(input stack_op_t op, input logic [DATA_W-1:0] res);
        run_op(int'(op.rd), int'(op.pop), int'(op.push), res);
    endtask

    initial begin
        int err_exp;
        do_reset();

        run_code(OP_PUSH0, 17'h00005);
        run_code(OP_PUSH1, 17'h00003);
        run_code(OP_ADD,   17'h00008);
        run_code(OP_DUP1,  17'h00008);
        run_code(OP_POP,   17'h1FFFF);
        run_code(OP_ISZERO, 17'h00000);
        chk("seq_sp", 32'(sp), 1);

        run_code(OP_ADD, 17'h00001);

        do_reset();
        for (int i = 0; i < DEPTH; i++)
            run_code(OP_PUSH0, DATA_W'($urandom_range(0, 17'h1FFFF)));
        chk("full_sp", 32'(sp), DEPTH);
        run_code(OP_MUL, 17'h12345);
        run_code(OP_PUSH1, 17'h0ABCD);
        run_code(OP_DUP1, 17'h00000);

        do_reset();
        run_op(1, 2, 0, '0);

        do_reset();
        run_code(OP_PUSH0, 17'h00007);
        issue(0, 0, 1, err_exp);
        chk("midrst_opnd_valid", 32'(opnd_valid), 1);
        sb.delete();
        res_valid = 1'b1;
        res_data  = 17'h00009;
        rst       = 1'b0;
        #1;
        chk("midrst_we", 32'(mem_we), 0);
        chk("midrst_en", 32'(mem_en), 0);
        @(negedge clk);
        res_valid = 1'b0;
        chk("midrst_sp", 32'(sp), 0);
        chk("midrst_ready", 32'(op_ready), 1);
        chk("midrst_opnd_valid_off", 32'(opnd_valid), 0);
        rst = 1'b1;
        model.delete();
        run_code(OP_PUSH0, 17'h00011);
        run_code(OP_DUP1, 17'h00022);
        run_code(OP_JUMPI, '0);
        chk("final_sp", 32'(sp), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Sequences all accesses to the processor's operand stack, which is held in an external single-port synchronous RAM.
- The instruction decoder issues one stack operation at a time: how many top entries to read, how many to pop, and whether to push.
- The block fetches the operands, hands them to the execute stage, and writes back the result.
- It enforces underflow/overflow checks and halts the core on a violation.

Parameters:
- DATA_W, 17, stack entry width in bits.
- DEPTH, 32, number of stack entries.
- PTR_W, $clog2(DEPTH)+1 (6), stack pointer width; holds 0..DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- op_valid  in  1  decoder request valid.
- op_ready  out  1  controller can accept a request.
- op_rd  in  2  number of top entries to read (0..2).
- op_pop  in  2  number of entries to remove (0..2).
- op_push  in  1  push one result.
- opnd_valid  out  1  operands presented.
- opnd_a  out  DATA_W  top of stack (0 if not read).
- opnd_b  out  DATA_W  second entry (0 if not read).
- res_valid  in  1  execute stage acknowledges operands and supplies the result.
- res_data  in  DATA_W  value to push.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  PTR_W-1  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented.
- sp  out  PTR_W  current stack depth.
- halted  out  1  sticky error halt.
- err_code  out  2  0 none, 1 underflow, 2 overflow, 3 illegal (op_pop>op_rd).

Behaviour:
- Reset (rst==0 at posedge, any state):
  - state=IDLE, sp=0, halted=0, err_code=0, opnd_a/b=0, opnd_valid=0.
  - mem_en=0 and mem_we=0 during the reset cycle, so any pending write is aborted.
- States: IDLE, RD_A, RD_B, CAP, OPND, HALT. op_ready=1 only in IDLE.
- Accept (IDLE, op_valid=1): the request fields are registered. Checks are evaluated in priority order: illegal, then underflow, then overflow.
  - Illegal: op_pop>op_rd.
  - Underflow: op_rd>sp.
  - Overflow: sp-op_pop+op_push>DEPTH.
  - On any error: go to HALT and latch err_code; no RAM access occurs.
  - Otherwise: go to RD_A if op_rd>0, else OPND.
- RD_A: mem_en=1, addr=sp-1. Next state is RD_B if op_rd==2, else CAP.
- RD_B: mem_en=1, addr=sp-2, opnd_a<=mem_rdata. Next state is CAP.
- CAP: captures mem_rdata into opnd_b if op_rd==2, else into opnd_a. Next state is OPND.
- OPND:
  - opnd_valid=1; operands are held stable until res_valid.
  - On res_valid:
    - If op_push: mem_en=1, mem_we=1, addr=sp-op_pop, wdata=res_data.
    - sp<=sp-op_pop+op_push; next state is IDLE.
- Latency from the accept edge to the first opnd_valid cycle: op_rd=0 gives 1 cycle, 1 gives 3, 2 gives 4. Minimum back-to-back op rate is one per (latency+1) cycles.
- Width rules:
  - sp arithmetic is done at PTR_W+1 bits for the overflow compare; there is no wrap.
  - sp==DEPTH is legal; the next push overflows.
- HALT: op_ready=0, opnd_valid=0, no RAM access. Stays here until reset; halted=1.
- op_valid outside IDLE is ignored; the decoder holds its request until op_ready.

Decomposition:
- Shared header StackCtrl.vh (alongside Opcodes.vh): state encodings, ERR_NONE/ERR_UNDERFLOW/ERR_OVERFLOW/ERR_ILLEGAL, and per-opcode {rd,pop,push} defines:
  - ADD/MUL/LT/EQ = {2,2,1}
  - ISZERO = {1,1,1}
  - POP = {1,1,0}
  - JUMPI = {2,2,0}
  - PUSH0/PUSH1 = {0,0,1}
  - DUP1 = {1,0,1}
- No sub-module. The stack RAM is instantiated by the parent. The bounds check is a combinational function inside this block.

Test Plan:
- Reset: hold rst=0 for 2 cycles → sp=0, op_ready=1, halted=0, mem_en=0, opnd_valid=0.
- PUSH {0,0,1}, res_data=0x0005, then again with 0x0003 → opnd_valid 1 cycle after each accept; writes addr0=0x5, addr1=0x3; sp=2.
- ADD {2,2,1} on [5,3]:
  - mem_addr 1 then 0 on consecutive cycles; opnd_valid 4 cycles after accept with opnd_a=0x3, opnd_b=0x5.
  - res_data=0x8 → write addr0=0x8, sp=1.
- DUP1 {1,0,1} on [8], res_data=0x8 → opnd_a=0x8 after 3 cycles; write addr1; sp=2. Then POP {1,1,0} → no mem_we; sp=1.
- Errors:
  - sp=1 and a {2,2,1} request → halted=1, err_code=1, no mem_en, op_ready=0 until rst=0.
  - 32 pushes then a 33rd → err_code=2.
  - A {1,2,0} request → err_code=3.
- Reset mid-operation: drive rst=0 in OPND with res_valid=1 and op_push=1 → mem_we=0 that cycle; next cycle sp=0, state IDLE.
